data_sync_mc: RTL and testbench

Multi-channel successor to the single-bus data synchronizer. It brings NUM_CH independent `unsync_bus`/`bus_enable` pairs into the `CLK` domain, using a NUM_STAGES flop chain per channel. The enable mode is selectable: level (rising edge) or toggle (any edge). Each channel has a one-deep holding register with overrun detection. A round-robin arbiter merges the captured words onto a single valid/ready output stream for the destination-domain consumers (register file, ALU front end).

---
 rtl/data_sync_mc.sv | 136 +++++++++++++
 tb/tb_data_sync_mc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_mc.sv
// data_sync_mc
//   Brings NUM_CH asynchronous bus/enable pairs into the CLK domain. Each
//   enable runs through a NUM_STAGES flop chain. An event is either a rising
//   edge (TOGGLE_MODE = 0) or any edge (TOGGLE_MODE = 1) of the synced enable.
//   Each event captures that channel's bus slice into a one-deep holding
//   register. A round-robin arbiter then merges the held words onto a single
//   valid/ready stream.
//
// Ports
//   CLK, RST      destination clock; synchronous active-high reset
//   unsync_bus    NUM_CH*BUS_WIDTH asynchronous data, channel i at [i*BUS_WIDTH +: BUS_WIDTH]
//   bus_enable    NUM_CH asynchronous enables
//   enable_pulse  NUM_CH registered one-cycle event pulses
//   out_data      merged output word
//   out_ch        channel index of out_data
//   out_valid     out_data/out_ch valid
//   out_ready     consumer ready
//   overrun       NUM_CH sticky overrun flags
//   overrun_clr   clears all overrun flags (a same-edge set wins)
//
// Handshake: a word transfers on a rising edge where out_valid & out_ready.
// While out_valid is high and out_ready is low, out_data/out_ch are held
// stable. The output register may be reloaded whenever it is empty or is
// being accepted on that edge.

module data_sync_mc #(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_CH      = 4,
  parameter int TOGGLE_MODE = 0,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [BUS_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]             out_ch,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_CH-1:0]           overrun,
  input  logic                        overrun_clr
);

  logic [NUM_STAGES-1:0] sync_q [NUM_CH];
  logic [BUS_WIDTH-1:0]  hold_q [NUM_CH];
  logic [NUM_CH-1:0]     last;
  logic [NUM_CH-1:0]     prev_q;
  logic [NUM_CH-1:0]     evt;
  logic [NUM_CH-1:0]     pending_q;
  logic [NUM_CH-1:0]     grant;
  logic [NUM_CH-1:0]     ovr_set;
  logic [CH_W-1:0]       rr_ptr;
  logic [CH_W-1:0]       gnt_idx;
  logic [CH_W-1:0]       rr_next;
  logic                  gnt_any;
  logic                  out_free;

  // Event detection on the synchronized enable
  for (genvar g = 0; g < NUM_CH; g++) begin : g_evt
    assign last[g] = sync_q[g][NUM_STAGES-1];
    if (TOGGLE_MODE != 0) begin : g_tog
      assign evt[g] = last[g] ^ prev_q[g];
    end else begin : g_lvl
      assign evt[g] = last[g] & ~prev_q[g];
    end
  end

  // Round-robin search starting at rr_ptr. Only words already pending are
  // considered, so an event landing on the same edge waits one cycle.
  always_comb begin
    int idx;
    idx      = 0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    rr_next  = '0;
    grant    = '0;
    out_free = ~out_valid | out_ready;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_any && pending_q[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(idx);
        rr_next = (idx == NUM_CH - 1) ? '0 : CH_W'(idx + 1);
      end
    end
    if (out_free && gnt_any) grant[gnt_idx] = 1'b1;
  end

  // A new word is dropped only when the held one is not leaving this edge
  assign ovr_set = evt & pending_q & ~grant;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= '0;
        hold_q[i] <= '0;
      end
      prev_q       <= '0;
      enable_pulse <= '0;
      pending_q    <= '0;
      overrun      <= '0;
      out_data     <= '0;
      out_ch       <= '0;
      out_valid    <= 1'b0;
      rr_ptr       <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= {sync_q[i][NUM_STAGES-2:0], bus_enable[i]};
        if (evt[i] && (!pending_q[i] || grant[i])) begin
          hold_q[i]    <= unsync_bus[i*BUS_WIDTH +: BUS_WIDTH];
          pending_q[i] <= 1'b1;
        end else if (grant[i]) begin
          pending_q[i] <= 1'b0;
        end
      end
      prev_q       <= last;
      enable_pulse <= evt;
      overrun      <= (overrun & ~{NUM_CH{overrun_clr}}) | ovr_set;

      if (out_free) begin
        if (gnt_any) begin
          out_data  <= hold_q[gnt_idx];
          out_ch    <= gnt_idx;
          out_valid <= 1'b1;
          rr_ptr    <= rr_next;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sync_mc.sv
module tb_data_sync_mc;

  localparam int NS  = 2;
  localparam int BW  = 8;
  localparam int NCH = 4;
  localparam int CW  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NCH*BW-1:0] unsync_bus;
  logic [NCH-1:0]    bus_enable;
  logic              out_ready;
  logic              overrun_clr;

  // level-mode DUT
  logic [NCH-1:0] enable_pulse;
  logic [BW-1:0]  out_data;
  logic [CW-1:0]  out_ch;
  logic           out_valid;
  logic [NCH-1:0] overrun;

  // toggle-mode DUT (shares inputs)
  logic [NCH-1:0] t_pulse;
  logic [BW-1:0]  t_data;
  logic [CW-1:0]  t_ch;
  logic           t_valid;
  logic [NCH-1:0] t_overrun;

  data_sync_mc #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NCH), .TOGGLE_MODE(0)) dut (
    .CLK(clk), .RST(rst), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .enable_pulse(enable_pulse), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  data_sync_mc #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NCH), .TOGGLE_MODE(1)) dut_t (
    .CLK(clk), .RST(rst), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .enable_pulse(t_pulse), .out_data(t_data), .out_ch(t_ch),
    .out_valid(t_valid), .out_ready(out_ready), .overrun(t_overrun),
    .overrun_clr(overrun_clr)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [CW+BW-1:0] exp_q[$];
  logic [CW+BW-1:0] exp_t_q[$];
  int pulse_cnt[NCH];
  int pulse_t_cnt[NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int ch, input logic [BW-1:0] v);
    unsync_bus[ch*BW +: BW] = v;
  endtask

  task automatic do_reset();
    bus_enable  = '0;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Runs n cycles, counting pulses and matching accepted words against the
  // expected queues. At iteration change_at, bus_enable[0] falls and ch0's
  // slice becomes 0x6B.
  task automatic drain(input int n, input bit with_t, input int change_at);
    for (int c = 0; c < NCH; c++) begin
      pulse_cnt[c]   = 0;
      pulse_t_cnt[c] = 0;
    end
    for (int i = 0; i < n; i++) begin
      if (i == change_at) begin
        bus_enable[0] = 1'b0;
        set_slice(0, 8'h6B);
      end
      tick();
      for (int c = 0; c < NCH; c++) begin
        if (enable_pulse[c]) pulse_cnt[c]++;
        if (t_pulse[c])      pulse_t_cnt[c]++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_word", 32'(out_valid), 0);
        else check("word", 32'({out_ch, out_data}), 32'(exp_q.pop_front()));
      end
      if (with_t && t_valid && out_ready) begin
        if (exp_t_q.size() == 0) check("extra_word_t", 32'(t_valid), 0);
        else check("word_t", 32'({t_ch, t_data}), 32'(exp_t_q.pop_front()));
      end
    end
    check("queue_empty", 32'(exp_q.size()), 0);
    if (with_t) check("queue_empty_t", 32'(exp_t_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b0;
    unsync_bus  = '0;
    bus_enable  = '0;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;

    // Reset with random inputs
    tick();
    rst = 1'b1;
    unsync_bus  = $urandom;
    bus_enable  = NCH'($urandom_range(0, 15));
    out_ready   = 1'($urandom_range(0, 1));
    overrun_clr = 1'($urandom_range(0, 1));
    tick();
    unsync_bus  = $urandom;
    bus_enable  = NCH'($urandom_range(0, 15));
    tick();
    check("rst_pulse",   32'(enable_pulse), 0);
    check("rst_valid",   32'(out_valid), 0);
    check("rst_data",    32'(out_data), 0);
    check("rst_ch",      32'(out_ch), 0);
    check("rst_overrun", 32'(overrun), 0);
    bus_enable  = '0;
    overrun_clr = 1'b0;
    out_ready   = 1'b1;
    rst         = 1'b0;
    drain(6, 1'b0, -1);
    check("idle_pulses", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 0);

    // Single event on ch1
    set_slice(1, 8'hA5);
    bus_enable[1] = 1'b1;
    tick();  // E1
    check("single_e1_pulse", 32'(enable_pulse), 0);
    tick();  // E2
    check("single_e2_pulse", 32'(enable_pulse), 0);
    tick();  // E3
    check("single_e3_pulse", 32'(enable_pulse), 32'h2);
    check("single_e3_valid", 32'(out_valid), 0);
    tick();  // E4
    check("single_e4_pulse", 32'(enable_pulse), 0);
    check("single_e4_valid", 32'(out_valid), 1);
    check("single_e4_data",  32'(out_data), 32'hA5);
    check("single_e4_ch",    32'(out_ch), 1);
    tick();  // E5
    check("single_e5_valid", 32'(out_valid), 0);

    // Round-robin across all four channels
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < NCH; c++) set_slice(c, 8'(8'h10 + c));
    bus_enable = 4'hF;
    tick(); tick(); tick();
    check("rr_pulse", 32'(enable_pulse), 32'hF);
    check("rr_valid_e3", 32'(out_valid), 0);
    for (int k = 0; k < NCH; k++) begin
      tick();
      check("rr_valid", 32'(out_valid), 1);
      check("rr_ch",    32'(out_ch), 32'(k));
      check("rr_data",  32'(out_data), 32'(8'h10 + k));
    end
    tick();
    check("rr_valid_end", 32'(out_valid), 0);
    check("rr_overrun",   32'(overrun), 0);

    // Backpressure and overrun on ch2
    do_reset();
    out_ready = 1'b0;
    set_slice(2, 8'h22); bus_enable[2] = 1'b1;
    tick(); tick();
    bus_enable[2] = 1'b0;
    tick(); tick();
    check("bp_valid",  32'(out_valid), 1);
    check("bp_data1",  32'(out_data), 32'h22);
    set_slice(2, 8'h33); bus_enable[2] = 1'b1;
    tick(); tick();
    bus_enable[2] = 1'b0;
    tick(); tick();
    check("bp_data2",     32'(out_data), 32'h22);
    check("bp_no_ovr",    32'(overrun), 0);
    set_slice(2, 8'h44); bus_enable[2] = 1'b1;
    tick(); tick();
    check("bp_no_ovr2",   32'(overrun), 0);
    tick();
    check("bp_overrun",   32'(overrun), 32'h4);
    check("bp_data3",     32'(out_data), 32'h22);
    check("bp_ch3",       32'(out_ch), 2);
    check("bp_valid3",    32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    check("bp_next_valid", 32'(out_valid), 1);
    check("bp_next_data",  32'(out_data), 32'h33);
    check("bp_next_ch",    32'(out_ch), 2);
    tick();
    check("bp_drained", 32'(out_valid), 0);
    drain(6, 1'b0, -1);
    check("bp_ovr_sticky", 32'(overrun), 32'h4);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("bp_ovr_clr", 32'(overrun), 0);

    // Level vs toggle mode
    do_reset();
    out_ready = 1'b1;
    set_slice(0, 8'h5A);
    bus_enable[0] = 1'b1;
    exp_q.push_back({2'd0, 8'h5A});
    exp_t_q.push_back({2'd0, 8'h5A});
    exp_t_q.push_back({2'd0, 8'h6B});
    drain(20, 1'b1, 6);
    check("mode_lvl_pulses", 32'(pulse_cnt[0]), 1);
    check("mode_tog_pulses", 32'(pulse_t_cnt[0]), 2);

    // Reset in mid-operation, enable held through release
    do_reset();
    out_ready = 1'b0;
    set_slice(0, 8'h01);
    set_slice(3, 8'h03);
    bus_enable = 4'b1001;
    tick(); tick(); tick(); tick();
    check("mid_valid", 32'(out_valid), 1);
    check("mid_ch",    32'(out_ch), 0);
    check("mid_data",  32'(out_data), 32'h01);
    rst = 1'b1;
    bus_enable = 4'b0010;
    set_slice(1, 8'h77);
    tick();
    check("mid_rst_pulse",   32'(enable_pulse), 0);
    check("mid_rst_valid",   32'(out_valid), 0);
    check("mid_rst_data",    32'(out_data), 0);
    check("mid_rst_ch",      32'(out_ch), 0);
    check("mid_rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back({2'd1, 8'h77});
    drain(12, 1'b0, -1);
    check("mid_ch1_pulses",   32'(pulse_cnt[1]), 1);
    check("mid_other_pulses", 32'(pulse_cnt[0] + pulse_cnt[2] + pulse_cnt[3]), 0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
